// File: rtl/hb_pkg.sv
// Shared constants and types for the halfband
// decimator control sequencer.
package hb_pkg;

  localparam int NUM_COEFFS = 8;
  localparam int NUM_TAPS   = 31;
  localparam int CENTER     = (NUM_TAPS - 1) / 2;
  localparam int ADDR_W     = 5;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [$clog2(NUM_COEFFS)-1:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Sample RAM address k taps older than base,
  // wrapping modulo the RAM depth.
  function automatic addr_t tap_addr(
    input addr_t base,
    input int    k
  );
    return addr_t'(int'(base) - k);
  endfunction

endpackage

// File: rtl/hb_sequencer_if.sv
// Strobe input and RAM/ROM/MAC control bundle
// of the halfband sequencer.
interface hb_sequencer_if;
  import hb_pkg::*;

  logic   enable;
  logic   strobe_in;
  logic   wr_en;
  addr_t  wr_addr;
  addr_t  rd_addr_a;
  addr_t  rd_addr_b;
  addr_t  center_addr;
  coeff_t coeff_addr;
  logic   mac_valid;
  logic   acc_first;
  logic   strobe_out;
  logic   busy;
  logic   overrun;

  modport master (
    output enable, strobe_in,
    input  wr_en, wr_addr,
    input  rd_addr_a, rd_addr_b,
    input  center_addr, coeff_addr,
    input  mac_valid, acc_first,
    input  strobe_out, busy, overrun
  );

  modport slave (
    input  enable, strobe_in,
    output wr_en, wr_addr,
    output rd_addr_a, rd_addr_b,
    output center_addr, coeff_addr,
    output mac_valid, acc_first,
    output strobe_out, busy, overrun
  );

endinterface

// File: rtl/hb_ctrl_delay.sv
// Delays the {run, first} control pair by PIPE
// cycles to line up with datapath products.
module hb_ctrl_delay #(
  parameter int PIPE = 2
) (
  input  logic clock,
  input  logic clr,
  input  logic run,
  input  logic first,
  output logic run_q,
  output logic first_q
);

  logic [1:0] sr [PIPE];

  // Shift register, flushed on clear.
  always_ff @(posedge clock) begin
    if (clr) begin
      for (int k = 0; k < PIPE; k++)
        sr[k] <= '0;
    end else begin
      sr[0] <= {run, first};
      for (int k = 1; k < PIPE; k++)
        sr[k] <= sr[k-1];
    end
  end

  assign run_q   = sr[PIPE-1][1];
  assign first_q = sr[PIPE-1][0];

endmodule

// File: rtl/hb_sequencer.sv
// Write pointer, decimation phase and 8-cycle
// MAC pass sequencing for the halfband filter.
module hb_sequencer
  import hb_pkg::*;
#(
  parameter int PIPE = 2
) (
  input  logic        clock,
  input  logic        reset,
  hb_sequencer_if.slave bus
);

  state_t state_q, state_d;
  addr_t  wr_ptr_q;
  addr_t  a_q, b_q, c_q;
  coeff_t i_q;
  logic   phase_q;
  logic   ovr_q;
  logic   mv_q;
  logic [2:0] dcnt_q;

  logic wr_en, start, idle, run;
  logic last, first, clr;
  logic mv, af;

  assign wr_en = bus.strobe_in & bus.enable;
  assign start = wr_en & phase_q;
  assign idle  = state_q == IDLE;
  assign run   = state_q == RUN;
  assign last  = i_q == coeff_t'(NUM_COEFFS-1);
  assign first = run & (i_q == '0);
  assign clr   = reset | ~bus.enable;

  // Pass sequencing: one run of 8, then drain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DRAIN;
      DRAIN:   if (dcnt_q == 3'(PIPE))
                 state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!bus.enable) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Pointer, phase, overrun and pass addresses.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      phase_q  <= 1'b0;
      ovr_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      i_q      <= '0;
      dcnt_q   <= '0;
    end else begin
      if (wr_en)
        wr_ptr_q <= wr_ptr_q + addr_t'(1);
      if (!bus.enable)
        phase_q <= 1'b0;
      else if (wr_en)
        phase_q <= ~phase_q;
      if (start & ~idle)
        ovr_q <= 1'b1;
      if (start & idle) begin
        a_q <= wr_ptr_q;
        b_q <= tap_addr(wr_ptr_q, NUM_TAPS-1);
        c_q <= tap_addr(wr_ptr_q, CENTER);
        i_q <= '0;
      end else if (run & ~last) begin
        a_q <= tap_addr(a_q, 2);
        b_q <= b_q + addr_t'(2);
        i_q <= i_q + coeff_t'(1);
      end
      dcnt_q <= (state_q == DRAIN) ?
                dcnt_q + 3'd1 : 3'd0;
    end
  end

  hb_ctrl_delay #(.PIPE(PIPE)) u_dly (
    .clock   (clock),
    .clr     (clr),
    .run     (run),
    .first   (first),
    .run_q   (mv),
    .first_q (af)
  );

  // Falling edge of mac_valid marks a finished sum.
  always_ff @(posedge clock) begin
    if (clr) mv_q <= 1'b0;
    else     mv_q <= mv;
  end

  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = wr_ptr_q;
  assign bus.rd_addr_a   = a_q;
  assign bus.rd_addr_b   = b_q;
  assign bus.center_addr = c_q;
  assign bus.coeff_addr  = i_q;
  assign bus.mac_valid   = mv;
  assign bus.acc_first   = af;
  assign bus.strobe_out  = mv_q & ~mv;
  assign bus.busy        = ~idle;
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_hb_sequencer.sv
// Self-checking bench for hb_sequencer with
// PIPE=2: vector table plus corner sequences.
module tb_hb_sequencer;
  import hb_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   so_cnt;
  int   mvc;

  hb_sequencer_if bus ();

  hb_sequencer #(.PIPE(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       s;
    addr_t      wa;
    logic       ck;
    addr_t      a;
    addr_t      b;
    addr_t      c;
    coeff_t     k;
    logic [5:0] ctl;
  } vec_t;

  vec_t tv [15];

  function automatic vec_t mk(
    input logic       s,
    input addr_t      wa,
    input logic       ck,
    input addr_t      a,
    input addr_t      b,
    input addr_t      c,
    input coeff_t     k,
    input logic [5:0] ctl
  );
    vec_t v;
    v.s = s; v.wa = wa; v.ck = ck;
    v.a = a; v.b = b; v.c = c;
    v.k = k; v.ctl = ctl;
    return v;
  endfunction

  function automatic logic [5:0] ctl_now();
    return {bus.wr_en, bus.mac_valid,
            bus.acc_first, bus.strobe_out,
            bus.busy, bus.overrun};
  endfunction

  function automatic logic [17:0] adr_now();
    return {bus.rd_addr_a, bus.rd_addr_b,
            bus.center_addr, bus.coeff_addr};
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  // One cycle: drive after the edge, sample mid-cycle.
  task automatic cyc(
    input logic s,
    input logic en = 1'b1,
    input logic r  = 1'b0
  );
    @(posedge clock);
    #1;
    bus.strobe_in = s;
    bus.enable    = en;
    reset         = r;
    @(negedge clock);
    if (bus.strobe_out === 1'b1) so_cnt++;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    so_cnt = 0;
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.strobe_in = 1'b0;

    tv[0]  = mk(1, 5'd0, 0, 5'd0, 5'd0, 5'd0,
                3'd0, 6'b100000);
    tv[1]  = mk(0, 5'd1, 0, 5'd0, 5'd0, 5'd0,
                3'd0, 6'b000000);
    tv[2]  = mk(1, 5'd1, 0, 5'd0, 5'd0, 5'd0,
                3'd0, 6'b100000);
    tv[3]  = mk(0, 5'd2, 1, 5'd1, 5'd3, 5'd18,
                3'd0, 6'b000010);
    tv[4]  = mk(0, 5'd2, 1, 5'd31, 5'd5, 5'd18,
                3'd1, 6'b000010);
    tv[5]  = mk(0, 5'd2, 1, 5'd29, 5'd7, 5'd18,
                3'd2, 6'b011010);
    tv[6]  = mk(0, 5'd2, 1, 5'd27, 5'd9, 5'd18,
                3'd3, 6'b010010);
    tv[7]  = mk(0, 5'd2, 1, 5'd25, 5'd11, 5'd18,
                3'd4, 6'b010010);
    tv[8]  = mk(0, 5'd2, 1, 5'd23, 5'd13, 5'd18,
                3'd5, 6'b010010);
    tv[9]  = mk(0, 5'd2, 1, 5'd21, 5'd15, 5'd18,
                3'd6, 6'b010010);
    tv[10] = mk(0, 5'd2, 1, 5'd19, 5'd17, 5'd18,
                3'd7, 6'b010010);
    tv[11] = mk(0, 5'd2, 0, 5'd0, 5'd0, 5'd0,
                3'd0, 6'b010010);
    tv[12] = mk(0, 5'd2, 0, 5'd0, 5'd0, 5'd0,
                3'd0, 6'b010010);
    tv[13] = mk(0, 5'd2, 0, 5'd0, 5'd0, 5'd0,
                3'd0, 6'b000110);
    tv[14] = mk(0, 5'd2, 0, 5'd0, 5'd0, 5'd0,
                3'd0, 6'b000000);

    // Reset values.
    do_reset();
    chk("rst_ctl", 32'(ctl_now()), 32'(0));
    chk("rst_adr", 32'(adr_now()), 32'(0));
    chk("rst_wa", 32'(bus.wr_addr), 32'(0));

    // First pass, base=1.
    for (int k = 0; k < 15; k++) begin
      cyc(tv[k].s);
      chk($sformatf("ctl[%0d]", k),
          32'(ctl_now()), 32'(tv[k].ctl));
      chk($sformatf("wa[%0d]", k),
          32'(bus.wr_addr), 32'(tv[k].wa));
      if (tv[k].ck)
        chk($sformatf("adr[%0d]", k),
            32'(adr_now()),
            32'({tv[k].a, tv[k].b,
                 tv[k].c, tv[k].k}));
    end

    // Max-rate stream with pointer wrap.
    do_reset();
    so_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1);
      chk($sformatf("wrap_wa[%0d]", k),
          32'(bus.wr_addr), 32'(k % 32));
      cyc(1'b0);
      if (k % 2 == 1) begin
        chk($sformatf("wrap_a[%0d]", k),
            32'(bus.rd_addr_a), 32'(k % 32));
        chk($sformatf("wrap_c[%0d]", k),
            32'(bus.center_addr),
            32'((k + 17) % 32));
      end
      for (int j = 0; j < 4; j++) cyc(1'b0);
    end
    for (int j = 0; j < 20; j++) cyc(1'b0);
    chk("wrap_passes", 32'(so_cnt), 32'(20));
    chk("wrap_ovr", 32'(bus.overrun), 32'(0));
    chk("wrap_wa_end", 32'(bus.wr_addr), 32'(8));

    // Too-fast strobes: second start dropped.
    do_reset();
    mvc = 0;
    for (int c = 0; c < 17; c++) begin
      cyc(c <= 8 && c % 2 == 0);
      if (bus.mac_valid === 1'b1) mvc++;
      if (c == 6)
        chk("ovr_before", 32'(bus.overrun), 32'(0));
      if (c == 7)
        chk("ovr_set", 32'(bus.overrun), 32'(1));
      if (c == 13)
        chk("ovr_so", 32'(bus.strobe_out), 32'(1));
      if (c == 14)
        chk("ovr_idle", 32'(bus.busy), 32'(0));
    end
    chk("ovr_mvc", 32'(mvc), 32'(8));
    chk("ovr_sticky", 32'(bus.overrun), 32'(1));
    chk("ovr_wa", 32'(bus.wr_addr), 32'(5));

    // enable dropped at RUN i=4.
    do_reset();
    for (int c = 0; c < 7; c++)
      cyc(c == 0 || c == 2 || c == 4);
    so_cnt = 0;
    cyc(1'b0, 1'b0);
    chk("en_i4", 32'(bus.coeff_addr), 32'(4));
    chk("en_busy7", 32'(bus.busy), 32'(1));
    cyc(1'b1, 1'b0);
    chk("en_ctl8", 32'(ctl_now()), 32'(0));
    chk("en_wa8", 32'(bus.wr_addr), 32'(3));
    cyc(1'b0);
    chk("en_wa9", 32'(bus.wr_addr), 32'(3));
    cyc(1'b1);
    cyc(1'b0);
    chk("en_phase", 32'(bus.busy), 32'(0));
    chk("en_wa11", 32'(bus.wr_addr), 32'(4));
    cyc(1'b1);
    cyc(1'b0);
    chk("en_restart", 32'(bus.busy), 32'(1));
    chk("en_a", 32'(bus.rd_addr_a), 32'(4));
    chk("en_c", 32'(bus.center_addr), 32'(21));
    for (int c = 14; c < 23; c++) cyc(1'b0);
    chk("en_no_so", 32'(so_cnt), 32'(0));
    cyc(1'b0);
    chk("en_so23", 32'(bus.strobe_out), 32'(1));
    chk("en_ovr", 32'(bus.overrun), 32'(0));

    // Reset asserted mid-DRAIN.
    do_reset();
    for (int c = 0; c < 12; c++)
      cyc(c <= 8 && c % 2 == 0);
    chk("rd_pre", 32'({bus.busy, bus.overrun}),
        32'(3));
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0);
    chk("rd_ctl", 32'(ctl_now()), 32'(0));
    chk("rd_adr", 32'(adr_now()), 32'(0));
    chk("rd_wa", 32'(bus.wr_addr), 32'(0));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
